nonrestoring_div: RTL and testbench

Sequential non-restoring divider: the inverse arithmetic counterpart of the shift/add Booth multiplier, sharing its operand/Request/Done handshake so a datapath can issue either operation through the same control sequence. Divides an N-bit dividend by an N-bit divisor, one quotient bit per clock, producing an N-bit quotient, an N-bit remainder and a divide-by-zero flag.

---
 rtl/div_pkg.sv | 17 +
 rtl/divctrl.sv | 69 ++++++
 rtl/nonrestoring_div.sv | 123 ++++++++++++
 tb/tb_nonrestoring_div.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider: state encoding
// and the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ITER    = 2'd1,
        ST_CORRECT = 2'd2,
        ST_DONE    = 2'd3
    } div_state_e;

    // Counter must hold 0..n_len.
    function automatic int unsigned cnt_width(input int unsigned n_len);
        return $clog2(n_len + 1);
    endfunction

endpackage

// File: rtl/divctrl.sv
// Divider control: Request/Done handshake FSM and iteration counter.
module divctrl
    import div_pkg::*;
#(
    parameter int unsigned N_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_request,
    output div_state_e o_state,
    output logic       o_done
);

    localparam int unsigned CNT_W = cnt_width(N_LEN);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_LEN - 1);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Request is only sampled in IDLE and DONE; a drop mid-operation is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_request) begin
                    w_state_nxt = ST_ITER;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ITER: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = ST_CORRECT;
                end
            end
            ST_CORRECT: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (!i_request) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_done  = r_done;

endmodule

// File: rtl/nonrestoring_div.sv
// Sequential non-restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN (config.v) for two's-complement operands; unsigned otherwise.
module nonrestoring_div
    import div_pkg::*;
#(
    parameter int unsigned N_LEN = 8
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Request,
    input  logic [N_LEN-1:0] op1,
    input  logic [N_LEN-1:0] op2,
    output logic [N_LEN-1:0] Quotient,
    output logic [N_LEN-1:0] Remainder,
    output logic             DivByZero,
    output logic             Done
);

    div_state_e       w_state;
    logic             w_done;
    logic [N_LEN:0]   r_p;
    logic [N_LEN-1:0] r_a;
    logic [N_LEN-1:0] r_d;
    logic [N_LEN-1:0] r_op1;
    logic             r_zero;
    logic [N_LEN-1:0] r_quot;
    logic [N_LEN-1:0] r_rem;
    logic             r_dbz;

    logic             w_load;
    logic [N_LEN-1:0] w_op1_mag;
    logic [N_LEN-1:0] w_op2_mag;
    logic [N_LEN:0]   w_p_sh;
    logic [N_LEN:0]   w_d_ext;
    logic [N_LEN:0]   w_p_nxt;
    logic [N_LEN-1:0] w_rem_mag;
    logic [N_LEN-1:0] w_q_fix;
    logic [N_LEN-1:0] w_r_fix;

    divctrl #(.N_LEN(N_LEN)) u_ctrl (
        .clk       (Clock),
        .rst_n     (nReset),
        .i_request (Request),
        .o_state   (w_state),
        .o_done    (w_done)
    );

    assign w_load = (w_state == ST_IDLE) && Request;

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_op1_mag = op1[N_LEN-1] ? N_LEN'(-op1) : op1;
    assign w_op2_mag = op2[N_LEN-1] ? N_LEN'(-op2) : op2;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_load) begin
            r_neg_q <= op1[N_LEN-1] ^ op2[N_LEN-1];
            r_neg_r <= op1[N_LEN-1];
        end
    end

    assign w_q_fix = r_neg_q ? N_LEN'(-r_a) : r_a;
    assign w_r_fix = r_neg_r ? N_LEN'(-w_rem_mag) : w_rem_mag;
`else
    assign w_op1_mag = op1;
    assign w_op2_mag = op2;
    assign w_q_fix   = r_a;
    assign w_r_fix   = w_rem_mag;
`endif

    // P wraps modulo 2^(N_LEN+1); the true value after +/-D always fits.
    assign w_d_ext   = {1'b0, r_d};
    assign w_p_sh    = {r_p[N_LEN-1:0], r_a[N_LEN-1]};
    assign w_p_nxt   = r_p[N_LEN] ? (w_p_sh + w_d_ext) : (w_p_sh - w_d_ext);
    assign w_rem_mag = r_p[N_LEN] ? (r_p[N_LEN-1:0] + r_d) : r_p[N_LEN-1:0];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_p    <= '0;
            r_a    <= '0;
            r_d    <= '0;
            r_op1  <= '0;
            r_zero <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (w_state)
                ST_IDLE: begin
                    if (Request) begin
                        r_p    <= '0;
                        r_a    <= w_op1_mag;
                        r_d    <= w_op2_mag;
                        r_op1  <= op1;
                        r_zero <= (op2 == '0);
                    end
                end
                ST_ITER: begin
                    r_p <= w_p_nxt;
                    r_a <= {r_a[N_LEN-2:0], ~w_p_nxt[N_LEN]};
                end
                ST_CORRECT: begin
                    r_quot <= r_zero ? '1 : w_q_fix;
                    r_rem  <= r_zero ? r_op1 : w_r_fix;
                    r_dbz  <= r_zero;
                end
                default: begin
                end
            endcase
        end
    end

    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign DivByZero = r_dbz;
    assign Done      = w_done;

endmodule

// File: tb/tb_nonrestoring_div.sv
// Scoreboard bench for nonrestoring_div (N_LEN=8); vectors follow DIV_SIGNED_EN.
module tb_nonrestoring_div;

    localparam int unsigned N = 8;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } exp_t;

    logic         Clock = 1'b0;
    logic         nReset = 1'b0;
    logic         Request = 1'b0;
    logic [N-1:0] op1 = '0;
    logic [N-1:0] op2 = '0;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         DivByZero;
    logic         Done;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    nonrestoring_div #(.N_LEN(N)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .Request   (Request),
        .op1       (op1),
        .op2       (op2),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero),
        .Done      (Done)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
            return e;
        end
`ifdef DIV_SIGNED_EN
        sa  = int'($signed(a));
        sb  = int'($signed(b));
`else
        sa  = int'({24'd0, a});
        sb  = int'({24'd0, b});
`endif
        e.q = N'(sa / sb);
        e.r = N'(sa % sb);
        e.z = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [N-1:0] q, input logic [N-1:0] r, input logic z);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        return e;
    endfunction

    // Issue one division; operands are scrambled after acceptance to show they are ignored.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e, input bit hold);
        int    lat;
        exp_t  x;
        string id;
        id = $sformatf("%0h/%0h", a, b);
        @(negedge Clock);
        op1     = a;
        op2     = b;
        Request = 1'b1;
        sb_q.push_back(e);
        @(posedge Clock);
        #1;
        if (!hold) Request = 1'b0;
        op1 = ~a;
        op2 = b ^ 8'h5A;
        lat = 0;
        while (!Done && lat < 20) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        check_val({"latency ", id}, lat, N + 1);
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check_val({"quotient ", id}, Quotient, x.q);
            check_val({"remainder ", id}, Remainder, x.r);
            check_val({"divbyzero ", id}, DivByZero, x.z);
        end
        if (!hold) begin
            @(posedge Clock);
            #1;
            check_val({"done_fall ", id}, Done, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int   highs;
        exp_t e;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        #1;
        check_val("reset_quotient", Quotient, 0);
        check_val("reset_remainder", Remainder, 0);
        check_val("reset_divbyzero", DivByZero, 0);
        check_val("reset_done", Done, 0);
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);

`ifdef DIV_SIGNED_EN
        run_div(8'd100, 8'd7, mk(8'd14, 8'd2, 1'b0), 1'b0);
        run_div(8'h9C, 8'd7, mk(8'hF2, 8'hFE, 1'b0), 1'b0);
        run_div(8'd100, 8'hF9, mk(8'hF2, 8'h02, 1'b0), 1'b0);
        run_div(8'h80, 8'hFF, mk(8'h80, 8'h00, 1'b0), 1'b0);
        run_div(8'h80, 8'd1, mk(8'h80, 8'h00, 1'b0), 1'b0);
        run_div(8'd5, 8'd0, mk(8'hFF, 8'h05, 1'b1), 1'b1);
`else
        run_div(8'd200, 8'd3, mk(8'd66, 8'd2, 1'b0), 1'b0);
        run_div(8'd100, 8'd7, mk(8'd14, 8'd2, 1'b0), 1'b0);
        run_div(8'd7, 8'd255, mk(8'd0, 8'd7, 1'b0), 1'b0);
        run_div(8'd255, 8'd1, mk(8'd255, 8'd0, 1'b0), 1'b0);
        run_div(8'd255, 8'd0, mk(8'hFF, 8'hFF, 1'b1), 1'b1);
`endif
        // Request held: Done and results must hold until Request drops.
        e = model(op1 ^ op1, 8'd0);
        repeat (3) @(posedge Clock);
        #1;
        check_val("hold_done", Done, 1'b1);
        check_val("hold_divbyzero", DivByZero, 1'b1);
        check_val("hold_quotient", Quotient, 8'hFF);
        @(negedge Clock);
        Request = 1'b0;
        @(posedge Clock);
        #1;
        check_val("hold_release_done", Done, 1'b0);
        check_val("hold_release_quotient", Quotient, e.q);

        run_div(8'd50, 8'd5, mk(8'd10, 8'd0, 1'b0), 1'b0);

        // Reset during ITER aborts the operation with no result.
        @(negedge Clock);
        op1     = 8'd100;
        op2     = 8'd7;
        Request = 1'b1;
        @(posedge Clock);
        #1;
        Request = 1'b0;
        repeat (4) @(posedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        check_val("midreset_quotient", Quotient, 0);
        check_val("midreset_remainder", Remainder, 0);
        check_val("midreset_divbyzero", DivByZero, 0);
        check_val("midreset_done", Done, 0);
        @(negedge Clock);
        nReset = 1'b1;
        highs  = 0;
        repeat (12) begin
            @(posedge Clock);
            #1;
            if (Done) highs++;
        end
        check_val("midreset_no_done", highs, 0);

        run_div(8'd100, 8'd7, model(8'd100, 8'd7), 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra = N'($urandom_range(0, 255));
            rb = N'($urandom_range(0, 255));
            if (i == 3) rb = '0;
            run_div(ra, rb, model(ra, rb), 1'b0);
        end

        check_val("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
